load_store_unit: RTL and testbench

- Responder side of the CPU LSU interface that the memory access stage drives.
- Accepts byte, halfword and word load/store commands and checks natural alignment.
- Runs one transaction at a time on the CPU data bus, using a req/ack handshake with byte enables.
- Returns right-aligned, zero-extended load data; stalls the pipeline through lsu_busy while a command is in flight.

---
 rtl/load_store_unit_pkg.sv | 27 ++
 rtl/lsu_lane_mux.sv | 54 +++++
 rtl/load_store_unit.sv | 119 +++++++++++
 tb/tb_load_store_unit.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings and alignment helper for the load/store unit
package load_store_unit_pkg;

    localparam int CPU_ADDR_WIDTH = 32;
    localparam int CPU_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'b00,
        CMD_BYTE  = 2'b01,
        CMD_HWORD = 2'b10,
        CMD_WORD  = 2'b11
    } lsu_cmd_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } lsu_state_e;

    function automatic logic is_misaligned(input lsu_cmd_e cmd, input logic [1:0] off);
        case (cmd)
            CMD_HWORD: return off[0];
            CMD_WORD:  return off != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_mux.sv
// rtl/lsu_lane_mux.sv - big-endian byte-lane placement for stores and extraction for loads
module lsu_lane_mux
    import load_store_unit_pkg::*;
(
    input  lsu_cmd_e    st_cmd,
    input  logic [1:0]  st_off,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] placed,
    input  lsu_cmd_e    ld_cmd,
    input  logic [1:0]  ld_off,
    input  logic [31:0] brdata,
    output logic [31:0] rdata
);

    always_comb begin
        be     = 4'b0000;
        placed = '0;
        case (st_cmd)
            CMD_BYTE: begin
                be     = 4'b1000 >> st_off;
                placed = {4{wdata[7:0]}};
            end
            CMD_HWORD: begin
                be     = st_off[1] ? 4'b0011 : 4'b1100;
                placed = {2{wdata[15:0]}};
            end
            CMD_WORD: begin
                be     = 4'b1111;
                placed = wdata;
            end
            default: ;
        endcase
    end

    // Byte offset 0 lives in the most significant lane.
    always_comb begin
        rdata = '0;
        case (ld_cmd)
            CMD_BYTE: begin
                case (ld_off)
                    2'd0:    rdata = {24'd0, brdata[31:24]};
                    2'd1:    rdata = {24'd0, brdata[23:16]};
                    2'd2:    rdata = {24'd0, brdata[15:8]};
                    default: rdata = {24'd0, brdata[7:0]};
                endcase
            end
            CMD_HWORD: rdata = ld_off[1] ? {16'd0, brdata[15:0]} : {16'd0, brdata[31:16]};
            CMD_WORD:  rdata = brdata;
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding LSU responder driving a req/ack data bus
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int TIMEOUT    = 256
)
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic [31:0]           lsu_wdata,
    input  logic [1:0]            lsu_cmd,
    input  logic                  lsu_rnw,
    output logic [31:0]           lsu_rdata,
    output logic                  lsu_busy,
    output logic                  lsu_err_align,
    output logic                  lsu_err_bus,
    output logic [ADDR_WIDTH-1:0] o_baddr,
    output logic [31:0]           o_bwdata,
    output logic [3:0]            o_bbe,
    output logic                  o_brnw,
    output logic                  o_breq,
    input  logic [31:0]           i_brdata,
    input  logic                  i_back,
    input  logic                  i_berr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    lsu_state_e    state, next_state;
    lsu_cmd_e      cmd, ld_cmd;
    logic [1:0]    ld_off;
    logic [CW-1:0] to_cnt;
    logic          start, misaligned, timed_out, fail;
    logic [3:0]    req_be;
    logic [31:0]   req_wdata, ld_data;

    assign cmd        = lsu_cmd_e'(lsu_cmd);
    assign misaligned = is_misaligned(cmd, lsu_addr[1:0]);
    assign start      = (state == ST_IDLE) && (cmd != CMD_IDLE);
    assign timed_out  = (TIMEOUT != 0) && (to_cnt == TO_LAST);
    assign fail       = (state == ST_BUS) && (i_berr || timed_out);
    // Combinational so the pipeline stalls in the very cycle the command appears.
    assign lsu_busy   = start || (state == ST_BUS);

    lsu_lane_mux u_lane_mux (
        .st_cmd (cmd),
        .st_off (lsu_addr[1:0]),
        .wdata  (lsu_wdata),
        .be     (req_be),
        .placed (req_wdata),
        .ld_cmd (ld_cmd),
        .ld_off (ld_off),
        .brdata (i_brdata),
        .rdata  (ld_data)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start && !misaligned) next_state = ST_BUS;
            ST_BUS:  if (i_back || i_berr || timed_out) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            lsu_rdata     <= '0;
            lsu_err_align <= 1'b0;
            lsu_err_bus   <= 1'b0;
            o_baddr       <= '0;
            o_bwdata      <= '0;
            o_bbe         <= 4'b0000;
            o_brnw        <= 1'b0;
            o_breq        <= 1'b0;
            to_cnt        <= '0;
            ld_cmd        <= CMD_IDLE;
            ld_off        <= 2'b00;
        end else begin
            lsu_err_align <= 1'b0;
            lsu_err_bus   <= 1'b0;
            if (start) begin
                if (misaligned) begin
                    lsu_err_align <= 1'b1;
                end else begin
                    o_baddr  <= {lsu_addr[ADDR_WIDTH-1:2], 2'b00};
                    o_brnw   <= lsu_rnw;
                    o_bbe    <= req_be;
                    o_bwdata <= req_wdata;
                    o_breq   <= 1'b1;
                    to_cnt   <= '0;
                    ld_cmd   <= cmd;
                    ld_off   <= lsu_addr[1:0];
                end
            end else if (state == ST_BUS) begin
                // Error wins over a simultaneous ack.
                if (fail) begin
                    o_breq      <= 1'b0;
                    lsu_rdata   <= '0;
                    lsu_err_bus <= 1'b1;
                end else if (i_back) begin
                    o_breq <= 1'b0;
                    if (o_brnw) lsu_rdata <= ld_data;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [1:0]  lsu_cmd = 2'b00;
    logic        lsu_rnw = 1'b0;
    logic [31:0] i_brdata = '0;
    logic        i_back = 1'b0;
    logic        i_berr = 1'b0;

    logic [31:0] lsu_rdata, o_baddr, o_bwdata;
    logic        lsu_busy, lsu_err_align, lsu_err_bus, o_brnw, o_breq;
    logic [3:0]  o_bbe;

    logic [31:0] t_rdata, t_baddr, t_bwdata;
    logic        t_busy, t_err_align, t_err_bus, t_brnw, t_breq;
    logic [3:0]  t_bbe;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_rdata = '0;

    always #5 clk = ~clk;

    load_store_unit u_dut (
        .clk(clk), .nrst(nrst), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_cmd(lsu_cmd), .lsu_rnw(lsu_rnw), .lsu_rdata(lsu_rdata), .lsu_busy(lsu_busy),
        .lsu_err_align(lsu_err_align), .lsu_err_bus(lsu_err_bus), .o_baddr(o_baddr),
        .o_bwdata(o_bwdata), .o_bbe(o_bbe), .o_brnw(o_brnw), .o_breq(o_breq),
        .i_brdata(i_brdata), .i_back(i_back), .i_berr(i_berr)
    );

    load_store_unit #(.TIMEOUT(4)) u_dut_to (
        .clk(clk), .nrst(nrst), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_cmd(lsu_cmd), .lsu_rnw(lsu_rnw), .lsu_rdata(t_rdata), .lsu_busy(t_busy),
        .lsu_err_align(t_err_align), .lsu_err_bus(t_err_bus), .o_baddr(t_baddr),
        .o_bwdata(t_bwdata), .o_bbe(t_bbe), .o_brnw(t_brnw), .o_breq(t_breq),
        .i_brdata(i_brdata), .i_back(i_back), .i_berr(i_berr)
    );

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({lsu_rdata, lsu_busy, lsu_err_align, lsu_err_bus, o_breq, o_baddr, o_bwdata, o_bbe, o_brnw} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs rdata=%h busy=%b ea=%b eb=%b req=%b addr=%h wd=%h be=%b rnw=%b required all zero",
                     lsu_rdata, lsu_busy, lsu_err_align, lsu_err_bus, o_breq, o_baddr, o_bwdata, o_bbe, o_brnw);
        end
        nrst = 1'b1;
        exp_rdata = '0;
        @(negedge clk);
    endtask

    // Reference: size in bytes, big-endian lane position computed arithmetically.
    task automatic run_txn(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic rnw, input int waits, input logic use_err, input logic [31:0] rd);
        int c, sz, k, sh;
        logic mis;
        logic [3:0]  ebe;
        logic [31:0] ebw, erd, mask;
        c   = int'(cmd);
        sz  = 1 << (c - 1);
        k   = int'(addr[1:0]);
        mis = (k % sz) != 0;
        ebe = '0; ebw = '0; erd = '0;
        if (!mis) begin
            sh   = 4 - sz - k;
            ebe  = 4'(((1 << sz) - 1) << sh);
            for (int j = 0; j < 4; j++) ebw[8*j +: 8] = wdata[8*(j % sz) +: 8];
            mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
            erd  = (rd >> (8 * sh)) & mask;
        end

        @(negedge clk);
        lsu_cmd = cmd; lsu_addr = addr; lsu_wdata = wdata; lsu_rnw = rnw;
        #1;
        n_cmp++;
        if (lsu_busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_cmd_cycle got=%b want=1", lsu_busy);
        end

        @(negedge clk);
        lsu_cmd = 2'b00;
        #1;
        if (mis) begin
            n_cmp++;
            if ({lsu_err_align, o_breq, lsu_busy, lsu_err_bus} !== 4'b1000 || lsu_rdata !== exp_rdata) begin
                n_bad++;
                $display("FAIL misalign_resp ea=%b req=%b busy=%b eb=%b rdata=%h want ea=1 req=0 busy=0 eb=0 rdata=%h",
                         lsu_err_align, o_breq, lsu_busy, lsu_err_bus, lsu_rdata, exp_rdata);
            end
            @(negedge clk);
            n_cmp++;
            if (lsu_err_align !== 1'b0 || o_breq !== 1'b0) begin
                n_bad++; $display("FAIL misalign_pulse ea=%b req=%b want 0 0", lsu_err_align, o_breq);
            end
            return;
        end

        n_cmp++;
        if (o_breq !== 1'b1 || lsu_busy !== 1'b1 || o_baddr !== {addr[31:2], 2'b00} ||
            o_bbe !== ebe || o_bwdata !== ebw || o_brnw !== rnw || lsu_err_align !== 1'b0) begin
            n_bad++;
            $display("FAIL bus_request req=%b busy=%b addr=%h be=%b wd=%h rnw=%b ea=%b want 1 1 %h %b %h %b 0",
                     o_breq, lsu_busy, o_baddr, o_bbe, o_bwdata, o_brnw, lsu_err_align,
                     {addr[31:2], 2'b00}, ebe, ebw, rnw);
        end

        for (int w = 0; w < waits; w++) begin
            lsu_cmd  = 2'($urandom);
            lsu_addr = $urandom;
            @(negedge clk);
            n_cmp++;
            if (o_breq !== 1'b1 || lsu_busy !== 1'b1 || o_baddr !== {addr[31:2], 2'b00} || o_bbe !== ebe) begin
                n_bad++;
                $display("FAIL bus_hold req=%b busy=%b addr=%h be=%b want 1 1 %h %b",
                         o_breq, lsu_busy, o_baddr, o_bbe, {addr[31:2], 2'b00}, ebe);
            end
        end

        lsu_cmd = 2'b00;
        i_brdata = rd;
        if (use_err) begin
            i_berr = 1'b1;
            i_back = 1'($urandom);
        end else begin
            i_back = 1'b1;
        end
        @(negedge clk);
        i_back = 1'b0; i_berr = 1'b0; i_brdata = $urandom;
        if (use_err)  exp_rdata = '0;
        else if (rnw) exp_rdata = erd;
        #1;
        n_cmp++;
        if (lsu_busy !== 1'b0 || o_breq !== 1'b0 || lsu_rdata !== exp_rdata ||
            lsu_err_bus !== use_err || lsu_err_align !== 1'b0) begin
            n_bad++;
            $display("FAIL completion busy=%b req=%b rdata=%h eb=%b ea=%b want 0 0 %h %b 0",
                     lsu_busy, o_breq, lsu_rdata, lsu_err_bus, lsu_err_align, exp_rdata, use_err);
        end
        @(negedge clk);
        n_cmp++;
        if (lsu_err_bus !== 1'b0 || lsu_rdata !== exp_rdata) begin
            n_bad++;
            $display("FAIL error_pulse_hold eb=%b rdata=%h want 0 %h", lsu_err_bus, lsu_rdata, exp_rdata);
        end
    endtask

    task automatic test_directed();
        run_txn(2'b11, 32'h0000_1000, 32'h0, 1'b1, 0, 1'b0, 32'hDEAD_BEEF);
        run_txn(2'b01, 32'h0000_1003, 32'h0, 1'b1, 0, 1'b0, 32'h1122_3344);
        n_cmp++;
        if (lsu_rdata !== 32'h0000_0044) begin
            n_bad++; $display("FAIL lb_1003 got=%h want=00000044", lsu_rdata);
        end
        run_txn(2'b01, 32'h0000_1000, 32'h0, 1'b1, 1, 1'b0, 32'h1122_3344);
        n_cmp++;
        if (lsu_rdata !== 32'h0000_0011) begin
            n_bad++; $display("FAIL lb_1000 got=%h want=00000011", lsu_rdata);
        end
        run_txn(2'b10, 32'h0000_2002, 32'hAAAA_5678, 1'b0, 0, 1'b0, 32'hFFFF_FFFF);
        run_txn(2'b11, 32'h0000_1002, 32'h0, 1'b1, 0, 1'b0, 32'h0);
        run_txn(2'b10, 32'h0000_1000, 32'h0, 1'b1, 3, 1'b1, 32'h1234_5678);
        n_cmp++;
        if (lsu_rdata !== 32'h0) begin
            n_bad++; $display("FAIL berr_rdata got=%h want=00000000", lsu_rdata);
        end
    endtask

    task automatic test_timeout();
        int high_cycles;
        high_cycles = 0;
        @(negedge clk);
        lsu_cmd = 2'b10; lsu_addr = 32'h0000_3000; lsu_rnw = 1'b1;
        @(negedge clk);
        lsu_cmd = 2'b00;
        for (int i = 0; i < 8 && t_breq === 1'b1; i++) begin
            high_cycles++;
            @(negedge clk);
        end
        n_cmp++;
        if (high_cycles != 4 || t_err_bus !== 1'b1 || t_breq !== 1'b0 || t_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL timeout req_cycles=%0d eb=%b req=%b rdata=%h want 4 1 0 00000000",
                     high_cycles, t_err_bus, t_breq, t_rdata);
        end
        i_berr = 1'b1;
        @(negedge clk);
        i_berr = 1'b0;
        exp_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus();
        @(negedge clk);
        lsu_cmd = 2'b11; lsu_addr = 32'h0000_4000; lsu_rnw = 1'b1;
        @(negedge clk);
        lsu_cmd = 2'b00;
        @(negedge clk);
        nrst = 1'b0;
        #1;
        n_cmp++;
        if (o_breq !== 1'b0 || lsu_busy !== 1'b0 || o_bbe !== 4'b0 || t_breq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_bus req=%b busy=%b be=%b treq=%b want 0 0 0000 0", o_breq, lsu_busy, o_bbe, t_breq);
        end
        @(negedge clk);
        nrst = 1'b1;
        exp_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [1:0]  cmd;
        logic [31:0] addr;
        for (int n = 0; n < 40; n++) begin
            cmd  = 2'($urandom_range(1, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (cmd == 2'b11) addr[1:0] = 2'b00;
                else if (cmd == 2'b10) addr[0] = 1'b0;
            end
            run_txn(cmd, addr, $urandom, 1'($urandom), $urandom_range(0, 2),
                    $urandom_range(0, 7) == 0, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid_bus();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
